// File: rtl/offchip_mem_model.sv
// offchip_mem_model: clocked off-chip memory behind the cache's four-phase
// read-request / read-data / write handshakes. Burst length, latency,
// handshake delay and widths are parameters.
// Optional build macro CRITICAL_WORD_FIRST_EN: the burst starts at the
// requested word and wraps inside the aligned block; otherwise it starts at
// word 0.
module offchip_mem_model #(
  parameter int DW  = 16,
  parameter int AW  = 16,
  parameter int BL  = 2,
  parameter int HS  = 3,
  parameter int LAT = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rrqst,
  input  logic          wrqst,
  input  logic          rdacpt,
  input  logic [DW-1:0] data_i,
  output logic          rrdy,
  output logic          rdrdy,
  output logic          wacpt,
  output logic [DW-1:0] data_o,
  output logic          data_oe,
  output logic [BL-1:0] burst_idx
);

  localparam int CMAX = (HS > LAT) ? HS : LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_REL, WDATA, WREL, LATENCY, PRESENT, ACK_LOW
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;      // 0 = waiting for trigger, else cycles since trigger
  logic [1:0]      cmd, cmd_n;      // {rrqst,wrqst} latched in IDLE
  logic [AW-1:0]   addr, addr_n;
  logic [DW-1:0]   wdata, wdata_n;
  logic [BL-1:0]   beat, beat_n;
  logic            rrdy_n, rdrdy_n, wacpt_n;
  logic [DW-1:0]   data_o_n;
  logic [BL-1:0]   idx_n;
  logic            ram_we;
  logic            armed, hs_hit, is_rd;
  logic [BL-1:0]   rd_beat, rd_idx;
  logic [DW-1:0]   rd_word;

  logic [DW-1:0]   mem [0:(2**AW)-1];

  assign data_oe = rdrdy;

  // Next-state, counter and handshake outputs; every wait reuses cnt.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cmd_n    = cmd;
    addr_n   = addr;
    wdata_n  = wdata;
    beat_n   = beat;
    rrdy_n   = rrdy;
    rdrdy_n  = rdrdy;
    wacpt_n  = wacpt;
    data_o_n = data_o;
    idx_n    = burst_idx;
    ram_we   = 1'b0;
    armed    = (cnt != '0);
    hs_hit   = (cnt == CW'(HS));
    is_rd    = (cmd == 2'b10);
    // Word presented on entry to PRESENT: beat 0 from LATENCY, else next beat.
    rd_beat  = (state == LATENCY) ? '0 : beat + BL'(1);
`ifdef CRITICAL_WORD_FIRST_EN
    rd_idx   = addr[BL-1:0] + rd_beat;
`else
    rd_idx   = rd_beat;
`endif
    rd_word  = mem[{addr[AW-1:BL], rd_idx}];

    case (state)
      IDLE: begin
        if (rrqst || wrqst) begin
          cmd_n   = {rrqst, wrqst};
          cnt_n   = CW'(1);
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (hs_hit) begin
          addr_n  = data_i;
          cnt_n   = '0;
          state_n = ADDR_REL;
          if (is_rd) rrdy_n  = 1'b1;
          else       wacpt_n = 1'b1;
        end else cnt_n = cnt + CW'(1);
      end
      ADDR_REL: begin
        if (!armed) begin
          if (!(is_rd ? rrqst : wrqst)) cnt_n = CW'(1);
        end else if (hs_hit) begin
          rrdy_n  = 1'b0;
          wacpt_n = 1'b0;
          if (is_rd) begin
            cnt_n   = CW'(1);
            state_n = LATENCY;
          end else begin
            cnt_n   = '0;
            state_n = WDATA;
          end
        end else cnt_n = cnt + CW'(1);
      end
      WDATA: begin
        if (!armed) begin
          if (wrqst) cnt_n = CW'(1);
        end else if (hs_hit) begin
          wdata_n = data_i;
          wacpt_n = 1'b1;
          cnt_n   = '0;
          state_n = WREL;
        end else cnt_n = cnt + CW'(1);
      end
      WREL: begin
        if (!armed) begin
          if (!wrqst) begin
            ram_we = 1'b1;
            cnt_n  = CW'(1);
          end
        end else if (hs_hit) begin
          wacpt_n = 1'b0;
          if (cmd == 2'b11) begin
            cnt_n   = CW'(1);
            state_n = LATENCY;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else cnt_n = cnt + CW'(1);
      end
      LATENCY: begin
        if (cnt == CW'(LAT)) begin
          beat_n   = '0;
          rdrdy_n  = 1'b1;
          idx_n    = rd_idx;
          data_o_n = rd_word;
          cnt_n    = '0;
          state_n  = PRESENT;
        end else cnt_n = cnt + CW'(1);
      end
      PRESENT: begin
        if (!armed) begin
          if (rdacpt) cnt_n = CW'(1);
        end else if (hs_hit) begin
          rdrdy_n = 1'b0;
          cnt_n   = '0;
          state_n = ACK_LOW;
        end else cnt_n = cnt + CW'(1);
      end
      ACK_LOW: begin
        if (!armed) begin
          if (!rdacpt) cnt_n = CW'(1);
        end else if (hs_hit) begin
          cnt_n = '0;
          if (beat == '1) state_n = IDLE;
          else begin
            beat_n   = rd_beat;
            rdrdy_n  = 1'b1;
            idx_n    = rd_idx;
            data_o_n = rd_word;
            state_n  = PRESENT;
          end
        end else cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= '0;
      addr      <= '0;
      wdata     <= '0;
      beat      <= '0;
      rrdy      <= 1'b0;
      rdrdy     <= 1'b0;
      wacpt     <= 1'b0;
      data_o    <= '0;
      burst_idx <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cmd       <= cmd_n;
      addr      <= addr_n;
      wdata     <= wdata_n;
      beat      <= beat_n;
      rrdy      <= rrdy_n;
      rdrdy     <= rdrdy_n;
      wacpt     <= wacpt_n;
      data_o    <= data_o_n;
      burst_idx <= idx_n;
    end
  end

  // Array write on the cycle wrqst release is seen; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) mem[addr] <= wdata;
  end

endmodule

// File: tb/tb_offchip_mem_model.sv
// Directed bench for offchip_mem_model: reset, preloads through the write
// handshake, read miss, write hit, write miss, reset mid-burst, slow acceptor.
module tb_offchip_mem_model;
  localparam int DW = 16, AW = 16, BL = 2, HS = 3, LAT = 10;

  logic          clock = 1'b0;
  logic          reset, rrqst, wrqst, rdacpt;
  logic [DW-1:0] data_i, data_o;
  logic          rrdy, rdrdy, wacpt, data_oe;
  logic [BL-1:0] burst_idx;

  int n_chk = 0, n_err = 0;
  int excl_err = 0, rd_hi = 0;
  logic [15:0] mdl [int];

  always #5 clock = ~clock;

  offchip_mem_model #(.DW(DW), .AW(AW), .BL(BL), .HS(HS), .LAT(LAT)) dut (
    .clock(clock), .reset(reset), .rrqst(rrqst), .wrqst(wrqst), .rdacpt(rdacpt),
    .data_i(data_i), .rrdy(rrdy), .rdrdy(rdrdy), .wacpt(wacpt),
    .data_o(data_o), .data_oe(data_oe), .burst_idx(burst_idx)
  );

  // Handshake outputs must stay one-hot-or-idle, and data_oe must track rdrdy.
  always @(posedge clock) begin
    if ($countones({rrdy, rdrdy, wacpt}) > 1 || data_oe !== rdrdy) excl_err <= excl_err + 1;
    if (rdrdy === 1'b1) rd_hi <= rd_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return rrdy;
      1:       return rdrdy;
      default: return wacpt;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int w, input logic v, output int n);
    n = 0;
    while (sig(w) !== v && n < 200) begin tick(); n++; end
    if (sig(w) !== v) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic reset_outs_zero(input string tag);
    chk({tag, "_ctl"}, {28'd0, rrdy, rdrdy, wacpt, data_oe}, 32'd0);
    chk({tag, "_data"}, {16'd0, data_o}, 32'd0);
    chk({tag, "_idx"}, {30'd0, burst_idx}, 32'd0);
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [15:0] d, input logic miss);
    int n;
    rrqst = miss; wrqst = 1'b1; data_i = a;
    wait_sig("wacpt_a_up", 2, 1'b1, n); chk("wacpt_a_up_lat", n, HS + 1);
    rrqst = 1'b0; wrqst = 1'b0;
    wait_sig("wacpt_a_dn", 2, 1'b0, n); chk("wacpt_a_dn_lat", n, HS + 1);
    data_i = d; wrqst = 1'b1;
    wait_sig("wacpt_d_up", 2, 1'b1, n); chk("wacpt_d_up_lat", n, HS + 1);
    wrqst = 1'b0;
    wait_sig("wacpt_d_dn", 2, 1'b0, n); chk("wacpt_d_dn_lat", n, HS + 1);
    data_i = '0;
    mdl[int'(a)] = d;
    if (!miss) repeat (2) tick();
  endtask

  task automatic read_txn(input logic [15:0] a);
    int n;
    rrqst = 1'b1; data_i = a;
    wait_sig("rrdy_up", 0, 1'b1, n); chk("rrdy_lat", n, HS + 1);
    rrqst = 1'b0; data_i = '0;
    wait_sig("rrdy_dn", 0, 1'b0, n); chk("rrdy_rel_lat", n, HS + 1);
    wait_sig("rdrdy_first", 1, 1'b1, n); chk("first_rdrdy_lat", n, LAT);
  endtask

  // Walks a burst that has just presented beat 0. stop: return with that
  // beat presented. slow: hold off acceptance of that beat for 20 cycles.
  task automatic burst(input logic [15:0] a, input int slow, input int stop);
    int n, dev;
    logic [1:0] bb, idx;
    logic [15:0] ad, d0;
    for (int b = 0; b < 4; b++) begin
      bb = b[1:0];
`ifdef CRITICAL_WORD_FIRST_EN
      idx = a[1:0] + bb;
`else
      idx = bb;
`endif
      ad = {a[15:2], idx};
      chk("burst_idx", {30'd0, burst_idx}, {30'd0, idx});
      chk("rdrdy_oe", {30'd0, rdrdy, data_oe}, 32'd3);
      if (mdl.exists(int'(ad))) chk("burst_word", {16'd0, data_o}, {16'd0, mdl[int'(ad)]});
      if (b == stop) return;
      if (b == slow) begin
        dev = 0; d0 = data_o;
        repeat (20) begin
          tick();
          if (rdrdy !== 1'b1 || data_o !== d0 || burst_idx !== idx) dev++;
        end
        chk("slow_hold", dev, 0);
      end
      rdacpt = 1'b1;
      wait_sig("rdrdy_dn", 1, 1'b0, n); chk("rdrdy_rel_lat", n, HS + 1);
      rdacpt = 1'b0;
      if (b < 3) begin
        wait_sig("rdrdy_next", 1, 1'b1, n); chk("next_beat_lat", n, HS + 1);
      end else begin
        repeat (HS + 3) tick();
        chk("post_burst_quiet", {28'd0, rrdy, rdrdy, wacpt, data_oe}, 32'd0);
      end
    end
  endtask

  task automatic rand_reset();
    reset = 1'b1;
    repeat (3) begin
      rrqst = 1'($urandom); wrqst = 1'($urandom); rdacpt = 1'($urandom);
      data_i = 16'($urandom);
      tick();
    end
  endtask

  initial begin
    int n, rd0;
    rrqst = 0; wrqst = 0; rdacpt = 0; data_i = '0;

    // Reset with random inputs
    rand_reset();
    reset_outs_zero("reset0");
    rrqst = 0; wrqst = 0; rdacpt = 0; data_i = '0; reset = 1'b0;
    tick();

    // Preload blocks 0x3008 and 0x3010 through the write handshake
    write_txn(16'h3008, 16'h1111, 1'b0);
    write_txn(16'h3009, 16'h0023, 1'b0);
    write_txn(16'h300A, 16'h0024, 1'b0);
    write_txn(16'h300B, 16'h300C, 1'b0);
    for (int i = 0; i < 4; i++) write_txn(16'h3010 + 16'(i), 16'h0000, 1'b0);

    // Reset again: contents retained
    rand_reset();
    reset_outs_zero("reset1");
    rrqst = 0; wrqst = 0; rdacpt = 0; data_i = '0; reset = 1'b0;
    tick();

    // Read miss of 0x3009
    read_txn(16'h3009);
    burst(16'h3009, -1, -1);

    // Write hit: no read data phase
    rd0 = rd_hi;
    write_txn(16'h300C, 16'h0024, 1'b0);
    repeat (LAT + 5) tick();
    chk("wr_hit_no_rdrdy", rd_hi - rd0, 0);
    read_txn(16'h300C);
    burst(16'h300C, -1, -1);

    // Write miss: write then burst returns the updated word
    write_txn(16'h3011, 16'h55AA, 1'b1);
    wait_sig("wmiss_rdrdy", 1, 1'b1, n); chk("wmiss_rdrdy_lat", n, LAT);
    burst(16'h3011, -1, -1);

    // Reset while beat 2 is presented
    read_txn(16'h3008);
    burst(16'h3008, -1, 2);
    reset = 1'b1;
    tick();
    reset_outs_zero("reset_mid");
    reset = 1'b0;
    tick();
    read_txn(16'h3008);
    burst(16'h3008, -1, -1);

    // Slow acceptor on beat 1
    read_txn(16'h3009);
    burst(16'h3009, 1, -1);

    chk("excl_oe", excl_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/offchip_mem_model.md
Name: offchip_mem_model

Overview:
Synthesizable, clocked, parametrised off-chip memory for the LC3 cache subsystem. It serves the cache's four-phase read-request, read-data and write handshakes, with burst length, latency, handshake delay, and address/data width configurable. All timing is counted in system-clock cycles; there are no `#` delays. It sits below the unified cache's memory interface; the top level builds the tristate bus from data_i, data_o and data_oe.

Parameters:
DW, 16, data word width
AW, 16, address width; array depth is 2**AW words
BL, 2, log2 of burst length (block = 2**BL words)
HS, 3, handshake delay in cycles (≥1) applied before every handshake response edge
LAT, 10, cycles from rrdy deassertion to first rdrdy (≥1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
rrqst  in  1  read request from cache
wrqst  in  1  write request / write-data strobe from cache
rdacpt  in  1  cache accepted current read word
data_i  in  DW  bus value driven by cache (address, then write data)
rrdy  out  1  read address accepted
rdrdy  out  1  read word valid on data_o
wacpt  out  1  write address/data accepted
data_o  out  DW  read word
data_oe  out  1  high when data_o must drive the bus (equals rdrdy)
burst_idx  out  BL  word offset within block of current data_o

Behaviour:
- Reset: rrdy, rdrdy, wacpt, data_oe = 0; data_o = 0; burst_idx = 0; FSM → IDLE; counters cleared. Array contents are retained. Reset mid-transaction aborts the transaction with no partial write and no further handshake edges.
- One shared delay counter. "Wait N" means the response edge is registered exactly N cycles after the triggering input is first sampled.
- IDLE samples {rrqst,wrqst} once. The command is latched and fixed for the whole transaction; later changes are ignored until the next IDLE.
  - 10: read miss
  - 01: write hit (write-through)
  - 11: write miss
  - 00: stay in IDLE
- ADDR: wait HS, latch addr ← data_i. For a read, assert rrdy; for a write or write-miss, assert wacpt.
- ADDR_REL: wait for the request line (rrqst for a read, wrqst otherwise) to go 0, then wait HS and deassert rrdy/wacpt.
  - Read → LATENCY.
  - Write → WDATA.
- WDATA: wait for wrqst=1, then wait HS, latch wdata ← data_i and assert wacpt.
- WREL: wait for wrqst=0.
  - The array write ram[addr] ← wdata occurs on the cycle wrqst=0 is sampled.
  - Then wait HS and deassert wacpt.
  - Write hit → IDLE. Write miss → LATENCY (write-allocate; the burst returns the updated word).
- LATENCY: count LAT cycles, then → PRESENT with beat=0.
- PRESENT:
  - Drive data_o = ram[{addr[AW-1:BL], idx}], burst_idx = idx, rdrdy = data_oe = 1.
  - data_o is stable while rdrdy is high; there is no timeout.
  - Wait for rdacpt=1, then wait HS and deassert rdrdy/data_oe.
- ACK_LOW: wait for rdacpt=0, then wait HS.
  - If this is the last beat (beat = 2**BL−1) → IDLE.
  - Otherwise beat+1 → PRESENT.
- idx = beat by default, giving word order 0..2**BL−1 (see optional feature). Arithmetic on idx is modulo 2**BL; the block never crosses its aligned boundary.
- rrdy, rdrdy and wacpt are mutually exclusive at all times.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: idx = (addr[BL-1:0] + beat) mod 2**BL, so the requested word is delivered first and the order wraps within the block.
- Undefined: idx = beat and the burst always starts at word 0.
- Beat count and handshakes are identical in both builds.

Test Plan:
1. Reset: hold reset 3 cycles with random inputs → all outputs 0, FSM in IDLE. Preloaded ram[0x3009]=0x0023 is unchanged after reset.
2. Read miss, default build: ram[0x3008..0x300B] = 0x1111, 0x0023, 0x0024, 0x300C; rrqst=1, data_i=0x3009.
   - rrdy rises 3 cycles after rrqst is sampled.
   - First rdrdy comes 10 cycles after rrdy falls.
   - Words 0x1111, 0x0023, 0x0024, 0x300C are delivered with burst_idx 0, 1, 2, 3, then IDLE.
   - With CRITICAL_WORD_FIRST_EN: order is 0x0023, 0x0024, 0x300C, 0x1111 with burst_idx 1, 2, 3, 0.
3. Write hit: address 0x300C, then data 0x0024 → wacpt pulses twice; ram[0x300C]=0x0024; rdrdy is never asserted.
4. Write miss: address 0x3011, data 0x55AA, with ram[0x3010..0x3013] = 0, 0, 0, 0.
   - Write completes, then a 4-beat burst returns 0x0000, 0x55AA, 0x0000, 0x0000.
5. Reset mid-burst: assert reset while rdrdy is high on beat 2 → rdrdy/data_oe are 0 on the next edge and the FSM is in IDLE. A following read of 0x3008 completes normally.
6. Slow acceptor: hold rdacpt=0 for 20 cycles during beat 1 → rdrdy=1, data_o and burst_idx stay constant. rdrdy drops exactly HS cycles after rdacpt rises.
